vga_ram_port_arbiter: RTL and testbench
=======================================

// Module: vga_ram_port_arbiter
// PURPOSE
//  Shares the single-port 1024x32 on-chip RAM between two requesters:
//  - FFT bin writer (wr_*).
//  - VGA bin reader (rd_*), which is real-time and latency-critical.
//  Reader has fixed priority. A wait counter forces a writer grant so the writer cannot starve.
//  Requests are registered onto the RAM's port-A signals. Read data is returned with a valid strobe.
// PARAMETERS
//  ADDR_W       10  RAM word address width (1024 words)
//  DATA_W       32  RAM data width
//  BE_W          4  byte-enable width, DATA_W/8
//  WR_MAX_WAIT   8  consecutive lost cycles before the writer is forced; legal range 1..255
//  STAT_W       16  statistics counter width
// PORTS
//  clk              in   1       system clock
//  reset_n          in   1       asynchronous active-low reset
//  wr_req           in   1       write request; hold it with wr_addr/wr_data/wr_be stable until wr_gnt
//  wr_addr          in   ADDR_W  write word address
//  wr_data          in   DATA_W  write data
//  wr_be            in   BE_W    write byte enables
//  wr_gnt           out  1       comb; write accepted at this clock edge
//  rd_req           in   1       read request; hold it with rd_addr stable until rd_gnt
//  rd_addr          in   ADDR_W  read word address
//  rd_gnt           out  1       comb; read accepted at this clock edge
//  rd_rdata         out  DATA_W  read data, registered
//  rd_rvalid        out  1       rd_rdata valid, one-cycle pulse per accepted read
//  ram_address      out  ADDR_W  RAM address, registered
//  ram_byteenable   out  BE_W    RAM byte enables, registered
//  ram_chipselect   out  1       RAM chipselect, registered
//  ram_write        out  1       RAM write, registered
//  ram_writedata    out  DATA_W  RAM write data, registered
//  ram_clken        out  1       RAM clock enable; constant 1 out of reset
//  ram_readdata     in   DATA_W  RAM q; valid the cycle after the RAM captures the address
//  stat_clr         in   1       synchronous clear of the statistics counters
//  stat_wr_cnt      out  STAT_W  number of accepted writes
//  stat_rd_cnt      out  STAT_W  number of accepted reads
//  stat_starve_cnt  out  STAT_W  number of forced writer grants
// BEHAVIOUR
//  - Reset (async, reset_n=0): every output register is 0 (ram_clken included), wait_cnt=0, read-valid pipe cleared.
//  - Arbitration is combinational from the current inputs:
//      force  = wr_req & (wait_cnt == WR_MAX_WAIT)
//      rd_gnt = rd_req & ~force
//      wr_gnt = wr_req & (~rd_req | force)
//    At most one grant per cycle.
//  - wait_cnt:
//      wr_req & ~wr_gnt  -> increment, saturating at WR_MAX_WAIT
//      wr_gnt or ~wr_req -> clear to 0
//  - Accept edge E0 (a grant is high):
//      ram_address / ram_byteenable / ram_writedata <= the winner's fields; read uses byteenable all-ones
//      ram_chipselect <= 1; ram_write <= wr_gnt
//  - No grant: ram_chipselect=0, ram_write=0; address and data hold their last values.
//  - Read latency: RAM captures the address at E1; rd_rdata <= ram_readdata at E2.
//    rd_rvalid is high for exactly the cycle after E2.
//  - 2-stage valid shift register. Back-to-back reads give 1 word per cycle, returned in order.
//  - wr_be=0 is still granted and counted; the RAM contents are unchanged.
//  - Reset mid-operation: in-flight reads are discarded; no rd_rvalid is issued after reset_n rises.
//  - ram_clken is 1 from the first edge after reset is released.
// CONFIGURATION
//  Macro VGA_RAM_ARB_STATS_EN.
//  - Defined:
//    - Three STAT_W counters increment on rd_gnt, on wr_gnt, and on wr_gnt&force respectively.
//    - Counters saturate at all-ones.
//    - stat_clr has priority over an increment in the same cycle.
//  - Undefined: the stat_* outputs are tied to 0, stat_clr is ignored, and no counter logic is built.
// TESTING
//  1. rd_req only, addrs 0..3 back-to-back, RAM preloaded with data=addr
//     -> rd_gnt each cycle; rd_rvalid for 4 cycles starting 2 cycles after the first accept; rd_rdata = 0,1,2,3.
//  2. wr_req only, addr 5, data 0xDEADBEEF, be=4'b0011
//     -> wr_gnt the same cycle; next cycle ram_write=1, ram_address=5, ram_byteenable=0011.
//  3. rd_req and wr_req held high continuously, WR_MAX_WAIT=8
//     -> rd wins 8 cycles, wr_gnt on the 9th (force); the pattern repeats; stat_starve_cnt increments once per 9 cycles.
//  4. Single read accepted, then reset_n pulsed low one cycle later
//     -> rd_rvalid never asserts; all outputs read 0 during reset.
//  5. STATS_EN defined, STAT_W=4, 20 reads
//     -> stat_rd_cnt=15 (saturated); stat_clr together with rd_gnt -> counter = 0.

Source files
------------

// File: rtl/vga_ram_port_arbiter.sv
// vga_ram_port_arbiter
//   Shares one single-port 1024x32 RAM between the FFT bin writer and the
//   VGA bin reader. The reader has fixed priority. A wait counter forces a
//   writer grant after WR_MAX_WAIT consecutive lost cycles, so the writer
//   cannot starve. Winning requests are registered onto the RAM port-A
//   signals. Read data is returned two edges after the accept edge, together
//   with a one-cycle rd_rvalid strobe.
//   Optional statistics counters are built only when the macro
//   VGA_RAM_ARB_STATS_EN is defined. Otherwise the stat_* outputs are tied to 0.
module vga_ram_port_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int BE_W        = DATA_W / 8,
    parameter int WR_MAX_WAIT = 8,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_rdata,
    output logic              rd_rvalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_rd_cnt,
    output logic [STAT_W-1:0] stat_starve_cnt
);

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [1:0]        rd_pipe_q, rd_pipe_d;
    logic [DATA_W-1:0] rd_rdata_q, rd_rdata_d;
    logic              rd_rvalid_q, rd_rvalid_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [BE_W-1:0]   ram_byteenable_q, ram_byteenable_d;
    logic              ram_chipselect_q, ram_chipselect_d;
    logic              ram_write_q, ram_write_d;
    logic [DATA_W-1:0] ram_writedata_q, ram_writedata_d;
    logic              ram_clken_q, ram_clken_d;
    logic              force_wr;

    // Arbitration: the reader wins unless the writer has waited its limit.
    always_comb begin
        force_wr = wr_req & (wait_cnt_q == 8'(WR_MAX_WAIT));
        rd_gnt   = rd_req & ~force_wr;
        wr_gnt   = wr_req & (~rd_req | force_wr);
    end

    // Next-state logic for the port registers, wait counter and read-valid pipe.
    always_comb begin
        wait_cnt_d       = 8'd0;
        ram_address_d    = ram_address_q;
        ram_byteenable_d = ram_byteenable_q;
        ram_writedata_d  = ram_writedata_q;
        ram_chipselect_d = rd_gnt | wr_gnt;
        ram_write_d      = wr_gnt;
        ram_clken_d      = 1'b1;
        if (wr_req && !wr_gnt && !force_wr) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else if (wr_req && !wr_gnt) begin
            wait_cnt_d = wait_cnt_q;
        end
        if (wr_gnt) begin
            ram_address_d    = wr_addr;
            ram_byteenable_d = wr_be;
            ram_writedata_d  = wr_data;
        end else if (rd_gnt) begin
            ram_address_d    = rd_addr;
            ram_byteenable_d = '1;
        end
        // Stage 0 marks the accept edge. Stage 1 marks the RAM capture edge.
        rd_pipe_d   = {rd_pipe_q[0], rd_gnt};
        rd_rvalid_d = rd_pipe_q[1];
        rd_rdata_d  = rd_pipe_q[1] ? ram_readdata : rd_rdata_q;
    end

    // State registers. Reset discards any reads still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q       <= '0;
            rd_pipe_q        <= '0;
            rd_rdata_q       <= '0;
            rd_rvalid_q      <= 1'b0;
            ram_address_q    <= '0;
            ram_byteenable_q <= '0;
            ram_chipselect_q <= 1'b0;
            ram_write_q      <= 1'b0;
            ram_writedata_q  <= '0;
            ram_clken_q      <= 1'b0;
        end else begin
            wait_cnt_q       <= wait_cnt_d;
            rd_pipe_q        <= rd_pipe_d;
            rd_rdata_q       <= rd_rdata_d;
            rd_rvalid_q      <= rd_rvalid_d;
            ram_address_q    <= ram_address_d;
            ram_byteenable_q <= ram_byteenable_d;
            ram_chipselect_q <= ram_chipselect_d;
            ram_write_q      <= ram_write_d;
            ram_writedata_q  <= ram_writedata_d;
            ram_clken_q      <= ram_clken_d;
        end
    end

    assign rd_rdata       = rd_rdata_q;
    assign rd_rvalid      = rd_rvalid_q;
    assign ram_address    = ram_address_q;
    assign ram_byteenable = ram_byteenable_q;
    assign ram_chipselect = ram_chipselect_q;
    assign ram_write      = ram_write_q;
    assign ram_writedata  = ram_writedata_q;
    assign ram_clken      = ram_clken_q;

`ifdef VGA_RAM_ARB_STATS_EN
    logic [STAT_W-1:0] stat_wr_q, stat_wr_d;
    logic [STAT_W-1:0] stat_rd_q, stat_rd_d;
    logic [STAT_W-1:0] stat_starve_q, stat_starve_d;

    // Saturating event counters. A clear wins over an increment in the same cycle.
    always_comb begin
        stat_wr_d     = stat_wr_q;
        stat_rd_d     = stat_rd_q;
        stat_starve_d = stat_starve_q;
        if (stat_clr) begin
            stat_wr_d     = '0;
            stat_rd_d     = '0;
            stat_starve_d = '0;
        end else begin
            if (wr_gnt && stat_wr_q != '1)
                stat_wr_d = stat_wr_q + 1'b1;
            if (rd_gnt && stat_rd_q != '1)
                stat_rd_d = stat_rd_q + 1'b1;
            if (wr_gnt && force_wr && stat_starve_q != '1)
                stat_starve_d = stat_starve_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_wr_q     <= '0;
            stat_rd_q     <= '0;
            stat_starve_q <= '0;
        end else begin
            stat_wr_q     <= stat_wr_d;
            stat_rd_q     <= stat_rd_d;
            stat_starve_q <= stat_starve_d;
        end
    end

    assign stat_wr_cnt     = stat_wr_q;
    assign stat_rd_cnt     = stat_rd_q;
    assign stat_starve_cnt = stat_starve_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_wr_cnt     = '0;
    assign stat_rd_cnt     = '0;
    assign stat_starve_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_ram_port_arbiter.sv
// Testbench for vga_ram_port_arbiter. It uses a behavioural synchronous RAM
// and a reference memory. Each read's expected data and due cycle are queued
// at grant time and checked when rd_rvalid appears.
module tb_vga_ram_port_arbiter;
    localparam int ADDR_W = 10, DATA_W = 32, BE_W = 4, WR_MAX_WAIT = 8, STAT_W = 4;
`ifdef VGA_RAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_req = 1'b0, rd_req = 1'b0, stat_clr = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [BE_W-1:0]   wr_be = '0;
    logic              wr_gnt, rd_gnt, rd_rvalid;
    logic [DATA_W-1:0] rd_rdata, ram_writedata, ram_q;
    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect, ram_write, ram_clken;
    logic [STAT_W-1:0] stat_wr_cnt, stat_rd_cnt, stat_starve_cnt;

    int vectors = 0;
    int errs    = 0;
    int ncyc    = 0;
    int rvalid_seen = 0;

    typedef struct { logic [DATA_W-1:0] data; int due; } exp_t;
    exp_t sb[$];

    logic [DATA_W-1:0] mem     [1024];
    logic [DATA_W-1:0] ref_mem [1024];
    bit mem_init = 1'b0, ref_init = 1'b0;

    vga_ram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .WR_MAX_WAIT(WR_MAX_WAIT), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rdata(rd_rdata), .rd_rvalid(rd_rvalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_q),
        .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
        .stat_starve_cnt(stat_starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-port synchronous RAM. It is preloaded with data equal to the address.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
            mem_init <= 1'b1;
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write)
                for (int b = 0; b < BE_W; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            ram_q <= mem[ram_address];
        end
    end

    // Scoreboard monitor. Grants push the expected data. rd_rvalid pops and compares.
    always @(negedge clk) begin
        ncyc++;
        if (!ref_init) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i);
            ref_init = 1'b1;
        end
        if (!reset_n) begin
            sb.delete();
        end else begin
            if (wr_gnt)
                for (int b = 0; b < BE_W; b++)
                    if (wr_be[b]) ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            if (rd_gnt) sb.push_back('{data: ref_mem[rd_addr], due: ncyc + 3});
            if (rd_rvalid) begin
                rvalid_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", 64'(rd_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_rdata", 64'(rd_rdata), 64'(e.data));
                    check("rvalid_cycle", 64'(ncyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_chipselect", 64'(ram_chipselect), 64'd0);
        check("rst_clken",      64'(ram_clken),      64'd0);
        check("rst_rvalid",     64'(rd_rvalid),      64'd0);
        check("rst_port_regs",  64'({ram_address, ram_byteenable, ram_write}), 64'd0);
        check("rst_writedata",  64'(ram_writedata),  64'd0);
        drive_edge(); reset_n = 1'b1;
        drive_edge(); @(negedge clk);
        check("clken_after_reset", 64'(ram_clken), 64'd1);

        // 1: back-to-back reads 0..3
        for (int a = 0; a < 4; a++) begin
            drive_edge(); rd_req = 1'b1; rd_addr = 10'(a);
            @(negedge clk);
            check("t1_rd_gnt", 64'({rd_gnt, wr_gnt}), 64'b10);
        end
        drive_edge(); rd_req = 1'b0;
        repeat (5) drive_edge();
        check("t1_drained", 64'(sb.size()), 64'd0);

        // 2: single write, then the port registers and a read-back
        drive_edge(); wr_req = 1'b1; wr_addr = 10'd5; wr_data = 32'hDEADBEEF; wr_be = 4'b0011;
        @(negedge clk);
        check("t2_wr_gnt", 64'({rd_gnt, wr_gnt}), 64'b01);
        drive_edge(); wr_req = 1'b0;
        @(negedge clk);
        check("t2_port", 64'({ram_chipselect, ram_write, ram_address, ram_byteenable}),
              64'({1'b1, 1'b1, 10'd5, 4'b0011}));
        check("t2_wdata", 64'(ram_writedata), 64'hDEADBEEF);
        drive_edge(); @(negedge clk);
        check("t2_idle", 64'({ram_chipselect, ram_write, ram_address}), 64'({1'b0, 1'b0, 10'd5}));
        // A write with zero byte enables is granted but leaves the word unchanged.
        drive_edge(); wr_req = 1'b1; wr_addr = 10'd6; wr_data = 32'hFFFFFFFF; wr_be = 4'b0000;
        @(negedge clk);
        check("t2_be0_gnt", 64'(wr_gnt), 64'd1);
        drive_edge(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 10'd5;
        drive_edge(); rd_addr = 10'd6;
        drive_edge(); rd_req = 1'b0;
        repeat (5) drive_edge();
        check("t2_drained", 64'(sb.size()), 64'd0);

        // 3: continuous contention, writer forced every 9th cycle
        drive_edge(); stat_clr = 1'b1;
        drive_edge(); stat_clr = 1'b0;
        rd_req = 1'b1; rd_addr = 10'd7;
        wr_req = 1'b1; wr_addr = 10'd8; wr_data = 32'h12345678; wr_be = 4'hF;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("t3_grants", 64'({rd_gnt, wr_gnt}), (i % 9 == 8) ? 64'b01 : 64'b10);
            drive_edge();
        end
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        check("t3_stat_starve", 64'(stat_starve_cnt), STATS ? 64'd2 : 64'd0);
        check("t3_stat_wr",     64'(stat_wr_cnt),     STATS ? 64'd2 : 64'd0);
        check("t3_stat_rd",     64'(stat_rd_cnt),     STATS ? 64'd15 : 64'd0);
        repeat (5) drive_edge();

        // 5: saturation of the read counter, then clear wins over increment
        drive_edge(); stat_clr = 1'b1;
        drive_edge(); stat_clr = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd_addr = 10'(i % 4);
            drive_edge();
        end
        rd_req = 1'b0;
        @(negedge clk);
        check("t5_stat_rd_sat", 64'(stat_rd_cnt), STATS ? 64'd15 : 64'd0);
        drive_edge(); stat_clr = 1'b1; rd_req = 1'b1; rd_addr = 10'd1;
        @(negedge clk);
        check("t5_clr_rd_gnt", 64'(rd_gnt), 64'd1);
        drive_edge(); stat_clr = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        check("t5_clr_prio", 64'(stat_rd_cnt), 64'd0);
        repeat (5) drive_edge();

        // 4: reset one cycle after a read is accepted
        seen = rvalid_seen;
        drive_edge(); rd_req = 1'b1; rd_addr = 10'd2;
        @(negedge clk);
        check("t4_rd_gnt", 64'(rd_gnt), 64'd1);
        drive_edge(); rd_req = 1'b0;
        drive_edge(); reset_n = 1'b0;
        @(negedge clk);
        check("t4_rst_outputs", 64'({ram_chipselect, ram_write, ram_clken, rd_rvalid, ram_address}), 64'd0);
        check("t4_rst_rdata", 64'(rd_rdata), 64'd0);
        check("t4_rst_stats", 64'({stat_wr_cnt, stat_rd_cnt, stat_starve_cnt}), 64'd0);
        drive_edge(); reset_n = 1'b1;
        repeat (6) drive_edge();
        check("t4_no_rvalid", 64'(rvalid_seen - seen), 64'd0);
        check("t4_clken", 64'(ram_clken), 64'd1);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
